// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - synchronized, staggered reset release with software reset handshake
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 4,
  parameter int STAGE_DELAY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               ready,
  output logic [1:0]         state_o
);

  localparam int CNT_W = $clog2(STAGE_DELAY + 1);
  localparam int IDX_W = $clog2(NUM_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(NUM_OUT);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    SW_ASSERT = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_q;
  logic                   req_rise;
  logic                   sync_rise;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;

  // Deassertion synchronizer: cleared asynchronously, fills with ones on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // The last stage turns high on the edge where its predecessor is already
  // high and it is not; that edge is where HOLD hands over to RELEASE.
  assign sync_rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

  // Software request edge detector; only a fresh rising edge counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= sw_rst_req;
    end
  end

  assign req_rise = sw_rst_req & ~req_q;

  // Sequencing FSM: all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      rst_n_out  <= '0;
      ready      <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      case (state)
        HOLD: begin
          if (sync_rise) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        RELEASE: begin
          if (idx == IDX_DONE) begin
            state <= RUN;
            ready <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            for (int k = 0; k < NUM_OUT; k++) begin
              if (idx == IDX_W'(k)) begin
                rst_n_out[k] <= 1'b1;
              end
            end
            cnt <= '0;
            idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (req_rise) begin
            state     <= SW_ASSERT;
            rst_n_out <= '0;
            ready     <= 1'b0;
            cnt       <= '0;
          end
        end
        SW_ASSERT: begin
          if (cnt == CNT_LAST) begin
            state      <= RELEASE;
            cnt        <= '0;
            idx        <= '0;
            sw_rst_ack <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
